// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_add_fa.sv
// Single-bit full adder shared by every bit position of the serial add.
// Purely combinational; no state, no handshake.
module serial_add_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: S/cout = A + B + cin, LSB first, one full-adder step per cycle.
// Latency: start in cycle 0 -> done pulse in cycle WIDTH+2; start is ignored while busy.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  serial_add_fa fa_bit (
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .z     (carry),
    .sum   (sum_bit),
    .carry (carry_nxt)
  );

  // New sum bit enters at the MSB so after WIDTH steps psum is aligned to S.
  assign psum_next = (psum >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= cin;
            busy  <= 1'b1;
            state <= LOAD;
`ifdef SERIAL_ADD_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end
        end
        LOAD: begin
          cnt   <= '0;
          psum  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= psum_next;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            S     <= psum_next;
            cout  <= carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
            // sum_bit is the MSB of the finished sum on this step.
            ovf   <= (a_msb == b_msb) && (sum_bit != a_msb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 16;

  logic         Clk;
  logic         Reset_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_s;
  logic         prev_c;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .S       (S),
`ifdef SERIAL_ADD_OVF_EN
    .ovf     (ovf),
`endif
    .cout    (cout)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at the negedge of an IDLE cycle; that cycle becomes cycle 0.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit disturb, input bit hold);
    logic [W:0]   full;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_v;
    int           done_cnt;
    int           done_cyc;
    bit           busy_bad;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    exp_s = full[W-1:0];
    exp_c = full[W];
    exp_v = (a[W-1] == b[W-1]) && (exp_s[W-1] != a[W-1]);
    done_cnt = 0;
    done_cyc = -1;
    busy_bad = 1'b0;
    A = a; B = b; cin = c; start = 1'b1;
    for (int cyc = 1; cyc <= W + 3; cyc++) begin
      @(negedge Clk);
      if (busy !== (cyc <= W + 1)) busy_bad = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == 10) begin
        check({tag, " S held mid-op"}, 32'(S), 32'(prev_s));
        check({tag, " cout held mid-op"}, 32'(cout), 32'(prev_c));
      end
      if (cyc == W + 2) begin
        check({tag, " S"}, 32'(S), 32'(exp_s));
        check({tag, " cout"}, 32'(cout), 32'(exp_c));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(exp_v));
`endif
      end
      // Inputs may change freely once captured; start outside IDLE must be ignored.
      if (disturb && cyc >= 2 && cyc <= W + 2) begin
        A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
        start = cyc[0];
      end else if (cyc >= 1) begin
        start = hold;
      end
    end
    check({tag, " busy window"}, 32'(busy_bad), 32'd0);
    check({tag, " done count"}, 32'(done_cnt), 32'd1);
    check({tag, " done cycle"}, 32'(done_cyc), 32'(W + 2));
    prev_s = exp_s;
    prev_c = exp_c;
    if (exp_v) begin end
  endtask

  initial begin
    int nd;
    Reset_n = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    prev_s = '0; prev_c = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset S", 32'(S), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_op("1+1", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("FFFF+0+1", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("7FFF+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    run_op("disturbed", 16'hA5A5, 16'h5A5B, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++)
      run_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);

    // Reset dominates a simultaneous start.
    Reset_n = 1'b0; start = 1'b1;
    @(negedge Clk);
    check("rst vs start busy", 32'(busy), 32'd0);
    Reset_n = 1'b1; start = 1'b0;
    @(negedge Clk);
    check("rst vs start idle", 32'(busy), 32'd0);
    check("rst vs start S", 32'(S), 32'd0);

    // Abort during SHIFT: reset lands at SHIFT step 8 (cycle 10).
    A = 16'h0F0F; B = 16'h1111; cin = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    Reset_n = 1'b0;
    @(negedge Clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort S", 32'(S), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    Reset_n = 1'b1;
    nd = 0;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge Clk);
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    check("abort no resume", 32'(nd), 32'd0);
    prev_s = '0; prev_c = 1'b0;
    run_op("1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check("1234+4321 const", 32'(S), 32'h5555);

    // Continuous start: each op's cycle 0 is the previous op's final IDLE cycle.
    run_op("b2b 0", W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1);
    run_op("b2b 1", W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b1);
    run_op("b2b 2", W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (legal 2..32).
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  addend, captured on accepted start.
REQ-006 SHALL have port B  input  WIDTH  addend, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in LOAD/SHIFT states.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port S  output  WIDTH  registered sum of last completed operation.
REQ-011 SHALL have port cout  output  1  registered carry-out of last completed operation.

Function
REQ-012 SHALL compute S/cout = A + B + cin bit-serially, LSB first, one shared single-bit full adder per cycle.
REQ-013 SHALL implement FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
REQ-014 IDLE: start=1 -> LOAD; start=0 -> stay; busy=0, done=0.
REQ-015 LOAD (1 cycle): A, B into shift regs, carry reg <- cin, bit counter <- 0, partial-sum reg <- 0; -> SHIFT.
REQ-016 SHIFT: per cycle, adder inputs = A_sr[0], B_sr[0], carry reg; sum bit enters partial-sum MSB, partial-sum/A_sr/B_sr shift right by 1, carry reg <- adder carry, counter +1.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; exit to DONE when counter = WIDTH-1 in that cycle; counter width = clog2(WIDTH).
REQ-018 On SHIFT->DONE transition S <- final partial sum, cout <- final carry; done=1 for the single DONE cycle; -> IDLE unconditionally.
REQ-019 Latency: start high in cycle 0 (IDLE) -> done high in cycle WIDTH+2; busy high cycles 1..WIDTH+1.
REQ-020 start in LOAD, SHIFT or DONE SHALL be ignored (no queuing); A/B/cin changes after capture SHALL not affect result.
REQ-021 S and cout SHALL hold last result from DONE until the next DONE; unchanged during computation.
REQ-022 Carry wrap: cout reflects carry out of bit WIDTH-1; S is sum modulo 2^WIDTH.

Reset
REQ-023 Reset_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, S=0, cout=0, shift regs/carry/counter=0.
REQ-024 Reset mid-SHIFT SHALL abort the operation; no done pulse; S/cout = 0.
REQ-025 Reset_n SHALL dominate start in the same cycle.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN defined: extra output port ovf (1 bit), registered with S, = two's-complement overflow (A[MSB]==B[MSB] and S[MSB]!=A[MSB]), operand MSBs saved in LOAD; reset 0.
REQ-027 Macro undefined: no ovf port, no MSB storage; all other behaviour identical.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state enum (IDLE, LOAD, SHIFT, DONE) and default WIDTH constant.
REQ-029 Single-bit adder SHALL be one sub-module instance named fa_bit (sum = x^y^z, carry = majority); no other arithmetic in the block.

Verification
REQ-030 A=0x0001, B=0x0001, cin=0, start pulse -> done at cycle 18 (WIDTH=16), S=0x0002, cout=0.
REQ-031 A=0xFFFF, B=0x0000, cin=1 -> S=0x0000, cout=1; ovf=0 with macro.
REQ-032 A=0x7FFF, B=0x0001, cin=0 with SERIAL_ADD_OVF_EN -> S=0x8000, cout=0, ovf=1.
REQ-033 Second start and changed A/B during SHIFT -> ignored; result of first operation only, single done pulse.
REQ-034 Reset_n=0 at SHIFT cycle 8 -> IDLE next cycle, no done, S=0, cout=0; subsequent 0x1234+0x4321 -> S=0x5555.
REQ-035 start held high continuously -> back-to-back operations, done every WIDTH+3 cycles, S updated each time.
